regfile_write_arbiter: RTL

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter_if.sv | 37 +++
 rtl/regfile_write_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter_if
// Description : Bundle of request, data and handshake signals between three
//               write requesters, the arbiter and the register bank.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_write_arbiter_if #(
    parameter int N     = 16,
    parameter int NREGS = 8
);
    logic [2:0]       Req;
    logic [2:0]       Addr0;
    logic [2:0]       Addr1;
    logic [2:0]       Addr2;
    logic [N-1:0]     Data0;
    logic [N-1:0]     Data1;
    logic [N-1:0]     Data2;
    logic [2:0]       Ack;
    logic [NREGS-1:0] Load;
    logic [N-1:0]     WrData;
    logic             Busy;
    logic [1:0]       GrantId;

    // Requester side: raises requests and receives completion/status.
    modport master (
        output Req, Addr0, Addr1, Addr2, Data0, Data1, Data2,
        input  Ack, Load, WrData, Busy, GrantId
    );

    // Arbiter side.
    modport slave (
        input  Req, Addr0, Addr1, Addr2, Data0, Data1, Data2,
        output Ack, Load, WrData, Busy, GrantId
    );
endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Arbitrates three write requesters onto a single register-bank
//               write port. One write takes three cycles: arbitrate/latch in
//               IDLE, one-hot Load in WRITE, Ack pulse in ACK.
//               Optional macro REGARB_ROUND_ROBIN_EN selects round-robin
//               arbitration; otherwise fixed priority 0 > 1 > 2.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int N     = 16,
    parameter int NREGS = 8
) (
    input  wire logic              Clk,
    input  wire logic              Reset,
    regfile_write_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_latch;

    logic [1:0]       r_grant;
    logic [2:0]       r_addr;
    logic [N-1:0]     r_data;

    logic [1:0]       w_win;
    logic [2:0]       w_addr;
    logic [N-1:0]     w_data;
    logic [NREGS-1:0] w_onehot;

    // State register; reset aborts any write in flight.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: a winner is latched only from IDLE.
    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        case (r_state)
            IDLE: begin
                if (|bus.Req) begin
                    w_latch      = 1'b1;
                    w_state_next = WRITE;
                end
            end
            WRITE:   w_state_next = ACK;
            ACK:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Winner selection. In round-robin mode the last grant is the pointer:
    // the requester after it has highest priority, the last winner lowest.
    always_comb begin
        w_win = 2'd0;
`ifdef REGARB_ROUND_ROBIN_EN
        case (r_grant)
            2'd0:    w_win = bus.Req[1] ? 2'd1 : (bus.Req[2] ? 2'd2 : 2'd0);
            2'd1:    w_win = bus.Req[2] ? 2'd2 : (bus.Req[0] ? 2'd0 : 2'd1);
            default: w_win = bus.Req[0] ? 2'd0 : (bus.Req[1] ? 2'd1 : 2'd2);
        endcase
`else
        w_win = bus.Req[0] ? 2'd0 : (bus.Req[1] ? 2'd1 : 2'd2);
`endif
    end

    // Address/data of the winning requester.
    always_comb begin
        w_addr = bus.Addr0;
        w_data = bus.Data0;
        case (w_win)
            2'd1: begin
                w_addr = bus.Addr1;
                w_data = bus.Data1;
            end
            2'd2: begin
                w_addr = bus.Addr2;
                w_data = bus.Data2;
            end
            default: begin
                w_addr = bus.Addr0;
                w_data = bus.Data0;
            end
        endcase
    end

    // Holding registers: the write proceeds from these, so requesters may
    // change or drop their inputs once latched. r_data doubles as WrData,
    // which therefore holds the last written value outside WRITE.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_grant <= 2'd2;
            r_addr  <= 3'd0;
            r_data  <= '0;
        end else if (w_latch) begin
            r_grant <= w_win;
            r_addr  <= w_addr;
            r_data  <= w_data;
        end
    end

    assign w_onehot = {{(NREGS-1){1'b0}}, 1'b1} << r_addr;

    // Outputs decode directly from state so reset clears them without a clock.
    always_comb begin
        bus.Load = '0;
        bus.Ack  = 3'b000;
        if (r_state == WRITE) begin
            bus.Load = w_onehot;
        end
        if (r_state == ACK) begin
            bus.Ack = 3'b001 << r_grant;
        end
    end

    assign bus.Busy    = (r_state != IDLE);
    assign bus.WrData  = r_data;
    assign bus.GrantId = r_grant;

endmodule
`default_nettype wire
